// File: rtl/alu_flag_branch_if.sv
// EX-stage bundle between the ALU flag logic and the branch resolver.
// The master drives the EX slot and reads back flags and the branch decision.
interface alu_flag_branch_if;
  logic       ex_valid;
  logic       flush;
  logic       set_flags;
  logic       alu_negative;
  logic       alu_zero;
  logic       alu_carry;
  logic       alu_overflow;
  logic [1:0] br_type;
  logic [3:0] cond;
  logic       rt_zero;
  logic [3:0] flags_q;
  logic       br_valid;
  logic       br_taken;
  logic       squashing;

  modport master (
    output ex_valid, flush, set_flags, alu_negative, alu_zero, alu_carry, alu_overflow,
           br_type, cond, rt_zero,
    input  flags_q, br_valid, br_taken, squashing
  );

  modport slave (
    input  ex_valid, flush, set_flags, alu_negative, alu_zero, alu_carry, alu_overflow,
           br_type, cond, rt_zero,
    output flags_q, br_valid, br_taken, squashing
  );
endinterface

// File: rtl/alu_flag_branch.sv
// Latches NZCV on flag-setting EX instructions, resolves B.cond/CBZ/CBNZ with a
// one-cycle registered decision, and ignores the wrong-path slots after a taken branch.
module alu_flag_branch #(
  parameter int unsigned SQUASH_CYCLES = 1
) (
  input logic               clk,
  input logic               reset_n,
  alu_flag_branch_if.slave  bus
);

  localparam logic [2:0] SquashInit = 3'(SQUASH_CYCLES);

  typedef enum logic [0:0] {StRun, StSquash} state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [3:0] flags_q;
  logic       br_valid_q;
  logic       br_taken_q;
  logic       squashing_q;

  logic       accept;
  logic       is_branch;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic       cond_base;
  logic       cond_true;
  logic       taken;

  assign accept    = bus.ex_valid & ~bus.flush & ~squashing_q;
  assign is_branch = (bus.br_type != 2'd0);
  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  // ARM encoding: cond[3:1] selects the test, cond[0] inverts it (except AL/NV).
  always_comb begin
    cond_base = 1'b0;
    unique case (bus.cond[3:1])
      3'd0: cond_base = z_flag;
      3'd1: cond_base = c_flag;
      3'd2: cond_base = n_flag;
      3'd3: cond_base = v_flag;
      3'd4: cond_base = c_flag & ~z_flag;
      3'd5: cond_base = (n_flag == v_flag);
      3'd6: cond_base = ~z_flag & (n_flag == v_flag);
      3'd7: cond_base = 1'b1;
    endcase
    cond_true = (bus.cond[3:1] == 3'd7) ? 1'b1 : (cond_base ^ bus.cond[0]);
  end

  always_comb begin
    taken = 1'b0;
    unique case (bus.br_type)
      2'd0: taken = 1'b0;
      2'd1: taken = cond_true;
      2'd2: taken = bus.rt_zero;
      2'd3: taken = ~bus.rt_zero;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StRun;
      cnt_q       <= 3'd0;
      flags_q     <= 4'b0000;
      br_valid_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      squashing_q <= 1'b0;
    end else begin
      if (accept && bus.set_flags) begin
        flags_q <= {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
      end
      br_valid_q <= accept & is_branch;
      br_taken_q <= accept & is_branch & taken;

      unique case (state_q)
        StRun: begin
          if (accept && is_branch && taken) begin
            state_q     <= StSquash;
            cnt_q       <= SquashInit;
            squashing_q <= 1'b1;
          end
        end
        StSquash: begin
          cnt_q <= cnt_q - 3'd1;
          // The slot on this edge is still ignored; accept sees squashing_q high.
          if (cnt_q == 3'd1) begin
            state_q     <= StRun;
            squashing_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StRun;
          squashing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flags_q   = flags_q;
  assign bus.br_valid  = br_valid_q;
  assign bus.br_taken  = br_taken_q;
  assign bus.squashing = squashing_q;

endmodule

// File: tb/tb_alu_flag_branch.sv
// Directed bench for alu_flag_branch: a slot-level reference model is compared against
// the DUT every cycle, and literal expectations pin key points of each scenario.
module tb_alu_flag_branch;

  localparam int Sq = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  alu_flag_branch_if bus ();

  alu_flag_branch #(.SQUASH_CYCLES(Sq)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Reference model state
  logic [3:0] m_flags = 4'b0000;
  logic       m_bv    = 1'b0;
  logic       m_bt    = 1'b0;
  int         m_skip  = 0;

  function automatic bit cond_holds(input logic [3:0] f, input logic [3:0] cd);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_flags = 4'b0000;
      m_bv    = 1'b0;
      m_bt    = 1'b0;
      m_skip  = 0;
    end else begin
      bit acc, tk;
      acc = bus.ex_valid && !bus.flush && (m_skip == 0);
      case (bus.br_type)
        2'd1:    tk = cond_holds(m_flags, bus.cond);
        2'd2:    tk = bus.rt_zero;
        2'd3:    tk = !bus.rt_zero;
        default: tk = 1'b0;
      endcase
      m_bv = acc && (bus.br_type != 2'd0);
      m_bt = m_bv && tk;
      if (acc && bus.set_flags)
        m_flags = {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow};
      if (m_skip > 0) m_skip = m_skip - 1;
      else if (m_bt) m_skip = Sq;
    end
  end

  always @(negedge clk) begin
    logic [6:0] act, exp;
    act = {bus.flags_q, bus.br_valid, bus.br_taken, bus.squashing};
    exp = {m_flags, m_bv, m_bt, (m_skip != 0)};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL model t=%0t actual flags/bv/bt/sq=%b required=%b", $time, act, exp);
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s t=%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.ex_valid = 0; bus.flush = 0; bus.set_flags = 0;
    bus.alu_negative = 0; bus.alu_zero = 0; bus.alu_carry = 0; bus.alu_overflow = 0;
    bus.br_type = 2'd0; bus.cond = 4'd0; bus.rt_zero = 0;
  endtask

  // One EX slot; returns just after the capturing edge with inputs back to idle.
  task automatic slot(input logic fl, input logic sf, input logic [3:0] nzcv,
                      input logic [1:0] bt, input logic [3:0] cd, input logic rtz);
    bus.ex_valid = 1; bus.flush = fl; bus.set_flags = sf;
    {bus.alu_negative, bus.alu_zero, bus.alu_carry, bus.alu_overflow} = nzcv;
    bus.br_type = bt; bus.cond = cd; bus.rt_zero = rtz;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic settle(); @(negedge clk); #1; endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    // 1 Reset with random inputs
    reset_n = 0;
    for (int i = 0; i < 3; i++) begin
      {bus.ex_valid, bus.set_flags, bus.alu_negative, bus.alu_zero} = 4'($urandom);
      {bus.alu_carry, bus.alu_overflow, bus.br_type} = 4'($urandom);
      bus.cond = 4'($urandom); bus.rt_zero = 1'($urandom);
      @(posedge clk); #1;
    end
    settle();
    chk("reset_flags", bus.flags_q, 4'b0000);
    chk("reset_bv_sq", {2'b00, bus.br_valid, bus.squashing}, 4'b0000);
    idle_inputs();
    reset_n = 1;
    idle(2);
    settle();
    chk("post_reset", {1'b0, bus.br_valid, bus.br_taken, bus.squashing}, 4'b0000);

    // 2 SUBS equal then B.EQ / B.NE
    slot(0, 1, 4'b0110, 2'd0, 4'd0, 0);
    settle(); chk("subs_flags", bus.flags_q, 4'b0110);
    slot(0, 0, 4'b0000, 2'd1, 4'd0, 0);
    settle(); chk("beq", {2'b00, bus.br_valid, bus.br_taken}, 4'b0011);
    idle(3);
    slot(0, 0, 4'b0000, 2'd1, 4'd1, 0);
    settle(); chk("bne", {1'b0, bus.br_valid, bus.br_taken, bus.squashing}, 4'b0100);

    // 3 Condition sweep with N1 Z0 C0 V0
    slot(0, 1, 4'b1000, 2'd0, 4'd0, 0);
    slot(0, 0, 4'b0000, 2'd1, 4'd10, 0);
    settle(); chk("ge", {2'b00, bus.br_valid, bus.br_taken}, 4'b0010);
    slot(0, 0, 4'b0000, 2'd1, 4'd11, 0);
    settle(); chk("lt", {2'b00, bus.br_valid, bus.br_taken}, 4'b0011);
    idle(3);
    slot(0, 0, 4'b0000, 2'd1, 4'd12, 0);
    settle(); chk("gt", {2'b00, bus.br_valid, bus.br_taken}, 4'b0010);
    slot(0, 0, 4'b0000, 2'd1, 4'd13, 0);
    settle(); chk("le", {2'b00, bus.br_valid, bus.br_taken}, 4'b0011);
    idle(3);
    slot(0, 0, 4'b0000, 2'd1, 4'd15, 0);
    settle(); chk("nv", {2'b00, bus.br_valid, bus.br_taken}, 4'b0011);
    idle(3);

    // 4 CBNZ / CBZ
    slot(0, 0, 4'b0000, 2'd3, 4'd0, 1);
    settle(); chk("cbnz", {2'b00, bus.br_valid, bus.br_taken}, 4'b0010);
    slot(0, 0, 4'b0000, 2'd2, 4'd0, 1);
    settle(); chk("cbz", {2'b00, bus.br_valid, bus.br_taken}, 4'b0011);
    chk("cbz_flags", bus.flags_q, 4'b1000);
    idle(3);

    // 5 Squash of two ADDS slots
    slot(0, 0, 4'b0000, 2'd1, 4'd14, 0);
    settle(); chk("bal_sq", {3'b000, bus.squashing}, 4'b0001);
    slot(0, 1, 4'b1111, 2'd0, 4'd0, 0);
    settle(); chk("sq1_flags", bus.flags_q, 4'b1000);
    chk("sq1_sq", {3'b000, bus.squashing}, 4'b0001);
    slot(0, 1, 4'b1111, 2'd0, 4'd0, 0);
    settle(); chk("sq2_flags", bus.flags_q, 4'b1000);
    chk("sq2_sq", {3'b000, bus.squashing}, 4'b0000);
    slot(0, 1, 4'b1111, 2'd0, 4'd0, 0);
    settle(); chk("third_flags", bus.flags_q, 4'b1111);

    // 6 Flush and reset during squash
    slot(1, 1, 4'b0000, 2'd0, 4'd0, 0);
    settle(); chk("flush_flags", bus.flags_q, 4'b1111);
    slot(1, 0, 4'b0000, 2'd1, 4'd14, 0);
    settle(); chk("flush_br", {1'b0, bus.br_valid, bus.br_taken, bus.squashing}, 4'b0000);
    slot(0, 0, 4'b0000, 2'd1, 4'd14, 0);
    #1 reset_n = 0;
    #1 chk("async_sq", {3'b000, bus.squashing}, 4'b0000);
    chk("async_flags", bus.flags_q, 4'b0000);
    settle();
    reset_n = 1;
    slot(0, 1, 4'b0101, 2'd0, 4'd0, 0);
    settle(); chk("first_after_reset", bus.flags_q, 4'b0101);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
